// File: rtl/led_test_pkg.sv
// Shared types and constants for the LED matrix self-test sequencer.
package led_test_pkg;

    localparam int NUM_ROWS        = 16;
    localparam int NUM_COLS        = 16;
    localparam int BOARD_ROW_FIRST = 10;
    localparam logic [NUM_COLS-1:0] BOARD_ROW_MASK = 16'hFE00;

    typedef enum logic [2:0] {
        SOLID_RED,
        SOLID_GRN,
        SOLID_YEL,
        BOARD,
        CHECKER,
        SWEEP
    } phase_t;

    typedef logic [NUM_ROWS-1:0][NUM_COLS-1:0] frame_t;

endpackage

// File: rtl/led_pattern_gen.sv
// Combinational map from (phase, sweep column) to the red and green frames.
module led_pattern_gen
    import led_test_pkg::*;
(
    input  phase_t     phase,
    input  logic [3:0] col,
    output frame_t     red,
    output frame_t     grn
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        red = '0;
        grn = '0;
        case (phase)
            SOLID_RED: red = '1;
            SOLID_GRN: grn = '1;
            SOLID_YEL: begin
                red = '1;
                grn = '1;
            end
            BOARD: begin
                for (int r = BOARD_ROW_FIRST; r < NUM_ROWS; r++)
                    red[r] = BOARD_ROW_MASK;
            end
            CHECKER: begin
                for (int r = 0; r < NUM_ROWS; r++)
                    for (int c = 0; c < NUM_COLS; c++) begin
                        red[r][c] = ((r + c) % 2) == 0;
                        grn[r][c] = ((r + c) % 2) != 0;
                    end
            end
            SWEEP: begin
                for (int r = 0; r < NUM_ROWS; r++)
                    grn[r][col] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/led_test.sv
// Self-test sequencer: steps through fixed full-frame patterns, each held TICK_DIV cycles.
module led_test
    import led_test_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                clk,
    input  logic                RST,
    output logic [15:0][15:0]   RedPixels,
    output logic [15:0][15:0]   GrnPixels
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div, div_nxt;
    phase_t           phase, phase_nxt;
    logic [3:0]       col, col_nxt;
    logic             tick;
    frame_t           red_pat, grn_pat;

    assign tick = (div == DIV_LAST);

    always_comb begin
        div_nxt   = tick ? '0 : div + DIV_W'(1);
        phase_nxt = phase;
        col_nxt   = col;
        if (tick) begin
            if (phase == SWEEP) begin
                if (col == 4'd15) begin
                    phase_nxt = SOLID_RED;
                    col_nxt   = '0;
                end else begin
                    col_nxt = col + 4'd1;
                end
            end else begin
                phase_nxt = phase_t'(phase + 3'd1);
            end
        end
    end

    led_pattern_gen u_pattern_gen (
        .phase (phase),
        .col   (col),
        .red   (red_pat),
        .grn   (grn_pat)
    );

    // Outputs register the pattern of the current state, giving one cycle of latency.
    always_ff @(posedge clk or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (RST) begin
            div       <= '0;
            phase     <= SOLID_RED;
            col       <= '0;
            RedPixels <= '0;
            GrnPixels <= '0;
        end else begin
            div       <= div_nxt;
            phase     <= phase_nxt;
            col       <= col_nxt;
            RedPixels <= red_pat;
            GrnPixels <= grn_pat;
        end
    end

endmodule

// File: tb/tb_led_test.sv
// Directed self-checking bench for led_test with TICK_DIV = 4 and TICK_DIV = 1.
module tb_led_test;

    logic clk;
    logic rst_a, rst_b;
    logic [15:0][15:0] red_a, grn_a, red_b, grn_b;

    int checks = 0;
    int errors = 0;

    led_test #(.TICK_DIV(4)) dut_a (
        .clk       (clk),
        .RST       (rst_a),
        .RedPixels (red_a),
        .GrnPixels (grn_a)
    );

    led_test #(.TICK_DIV(1)) dut_b (
        .clk       (clk),
        .RST       (rst_b),
        .RedPixels (red_b),
        .GrnPixels (grn_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected frames per sequence slot (0..20), written from the pattern table.
    function automatic logic [15:0][15:0] exp_red(input int slot);
        logic [15:0][15:0] f;
        f = '0;
        case (slot)
            0, 2: f = '1;
            3: for (int r = 10; r < 16; r++) f[r] = 16'hFE00;
            4: for (int r = 0; r < 16; r++) f[r] = (r % 2 == 0) ? 16'h5555 : 16'hAAAA;
            default: ;
        endcase
        return f;
    endfunction

    function automatic logic [15:0][15:0] exp_grn(input int slot);
        logic [15:0][15:0] f;
        f = '0;
        if (slot == 1 || slot == 2) f = '1;
        else if (slot == 4)
            for (int r = 0; r < 16; r++) f[r] = (r % 2 == 0) ? 16'hAAAA : 16'h5555;
        else if (slot >= 5)
            for (int r = 0; r < 16; r++) f[r] = 16'h0001 << (slot - 5);
        return f;
    endfunction

    task automatic edge_a();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Reset hold
        for (int i = 0; i < 5; i++) begin
            edge_a();
            check($sformatf("rst_hold_red_%0d", i), red_a, '0);
            check($sformatf("rst_hold_grn_%0d", i), grn_a, '0);
        end

        @(negedge clk) rst_a = 1'b0;
        #1;
        check("release_pre_edge_red", red_a, '0);

        // Full sequence, wrap and repeat of SOLID_RED
        for (int e = 1; e <= 88; e++) begin
            int slot;
            edge_a();
            slot = ((e - 1) / 4) % 21;
            check($sformatf("seq_e%0d_red", e), red_a, exp_red(slot));
            check($sformatf("seq_e%0d_grn", e), grn_a, exp_grn(slot));
            if (e == 13) begin
                check("board_row9", 256'(red_a[9]), 256'(16'h0000));
                check("board_row10", 256'(red_a[10]), 256'(16'hFE00));
                check("board_row15", 256'(red_a[15]), 256'(16'hFE00));
            end
            if (e == 17) begin
                check("checker_red0", 256'(red_a[0]), 256'(16'h5555));
                check("checker_red1", 256'(red_a[1]), 256'(16'hAAAA));
                check("checker_grn0", 256'(grn_a[0]), 256'(16'hAAAA));
            end
            if (e == 21) check("sweep_first_row7", 256'(grn_a[7]), 256'(16'h0001));
            if (e == 81) check("sweep_last_row3", 256'(grn_a[3]), 256'(16'h8000));
            if (e == 85) check("wrap_solid_red", red_a, '1);
        end

        // Async reset mid-sweep
        @(negedge clk) rst_a = 1'b1;
        @(negedge clk) rst_a = 1'b0;
        for (int e = 1; e <= 40; e++) edge_a();
        check("pre_async_grn", grn_a, exp_grn(9));
        #2 rst_a = 1'b1;
        #1;
        check("async_rst_red", red_a, '0);
        check("async_rst_grn", grn_a, '0);
        edge_a();
        check("async_hold_grn", grn_a, '0);
        @(negedge clk) rst_a = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            int slot;
            edge_a();
            slot = (e - 1) / 4;
            check($sformatf("restart_e%0d_red", e), red_a, exp_red(slot));
            check($sformatf("restart_e%0d_grn", e), grn_a, exp_grn(slot));
        end

        // TICK_DIV = 1: one slot per edge
        @(negedge clk) rst_b = 1'b0;
        for (int e = 1; e <= 22; e++) begin
            int slot;
            edge_a();
            slot = (e - 1) % 21;
            check($sformatf("td1_e%0d_red", e), red_b, exp_red(slot));
            check($sformatf("td1_e%0d_grn", e), grn_b, exp_grn(slot));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
